// File: rtl/wishbone_pkg.sv
// Shared types for the Wishbone master: FSM states, response status codes
// and the packed views of the bus signals driven/sampled by the master.
package wishbone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_BACKOFF = 2'b10,
    ST_RESP    = 2'b11
  } wb_state_e;

  typedef enum logic [1:0] {
    WB_OK      = 2'b00,
    WB_ERR     = 2'b01,
    WB_RTY_EXH = 2'b10,
    WB_TIMEOUT = 2'b11
  } wb_status_e;

  // Signals driven by the master (tags excluded: their width is per-instance).
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        lock;
  } wb_master_bus_t;

  // Signals sampled by the master from the shared response bus and arbiter.
  typedef struct packed {
    logic [31:0] dat;
    logic        ack;
    logic        err;
    logic        rty;
    logic        gnt;
  } wb_slave_bus_t;

endpackage

// File: rtl/wishbone_master_if.sv
// Wishbone bus bundle between one master and the interconnect.
interface wishbone_master_if #(
  parameter int TAGSIZE = 2
) ();

  logic [31:0]        wb_adr_o;
  logic [31:0]        wb_dat_o;
  logic [3:0]         wb_sel_o;
  logic               wb_we_o;
  logic               wb_cyc_o;
  logic               wb_stb_o;
  logic               wb_lock_o;
  logic [TAGSIZE-1:0] wb_tga_o;
  logic [TAGSIZE-1:0] wb_tgd_o;
  logic [TAGSIZE-1:0] wb_tgc_o;
  logic [31:0]        wb_dat_i;
  logic               wb_ack_i;
  logic               wb_err_i;
  logic               wb_rty_i;
  logic               wb_gnt_i;
  logic [TAGSIZE-1:0] wb_tgd_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
           wb_lock_o, wb_tga_o, wb_tgd_o, wb_tgc_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_gnt_i, wb_tgd_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
           wb_lock_o, wb_tga_o, wb_tgd_o, wb_tgc_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_gnt_i, wb_tgd_i
  );

endinterface

// File: rtl/wishbone_master.sv
// Single-transaction Wishbone master. Accepts one request, runs the bus cycle
// with retry/backoff and a timeout, and returns a one-cycle response pulse.
//
// Handshake: the request side uses valid/ready; a request transfers on a
// rising edge where req_valid_i and req_ready_o are both high. req_ready_o is
// high only while idle and does not depend on req_valid_i. The response side
// has no back-pressure: rsp_valid_o is a single-cycle pulse and rsp_dat_o /
// rsp_status_o hold their values until the next completion.
module wishbone_master
  import wishbone_pkg::*;
#(
  parameter int TAGSIZE   = 2,
  parameter int MAX_RETRY = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_adr_i,
  input  logic [31:0] req_dat_i,
  input  logic [3:0]  req_sel_i,
  input  logic        req_lock_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_dat_o,
  output logic [1:0]  rsp_status_o,
  wishbone_master_if.master wb_bus,
  output wb_state_e   state_o
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  wb_state_e      state_q, state_d;
  logic [RW-1:0]  retry_q;
  logic [TW-1:0]  tmo_q;
  logic [RW-1:0]  retry_next;
  logic [TW-1:0]  tmo_next;

  logic [31:0]    adr_q, dat_q;
  logic [3:0]     sel_q;
  logic           we_q, lock_q;
  logic [31:0]    rsp_dat_q;
  wb_status_e     rsp_status_q;

  wb_master_bus_t bus_out;
  wb_slave_bus_t  bus_in;

  logic           accept;
  logic           qual, q_err, q_ack, q_rty, q_term;
  logic           retry_hit, tmo_hit;
  logic           unused_tgd;

  assign bus_in.dat = wb_bus.wb_dat_i;
  assign bus_in.ack = wb_bus.wb_ack_i;
  assign bus_in.err = wb_bus.wb_err_i;
  assign bus_in.rty = wb_bus.wb_rty_i;
  assign bus_in.gnt = wb_bus.wb_gnt_i;
  // Incoming data tags carry nothing this master needs.
  assign unused_tgd = ^wb_bus.wb_tgd_i;

  // Terminations count only in REQ with our grant: the response bus is shared.
  // Priority among simultaneous terminations is err > ack > rty.
  always_comb begin
    accept     = (state_q == ST_IDLE) && req_valid_i;
    qual       = (state_q == ST_REQ) && bus_in.gnt;
    q_err      = qual && bus_in.err;
    q_ack      = qual && bus_in.ack && !bus_in.err;
    q_rty      = qual && bus_in.rty && !bus_in.err && !bus_in.ack;
    q_term     = q_err || q_ack || q_rty;
    retry_next = retry_q + 1'b1;
    tmo_next   = tmo_q + 1'b1;
    retry_hit  = (retry_next == RW'(MAX_RETRY));
    // A qualified termination in the timeout cycle wins over the timeout.
    tmo_hit    = (state_q == ST_REQ) && !q_term && (tmo_next == TW'(TIMEOUT));
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept) state_d = ST_REQ;
      ST_REQ: begin
        if (q_err || q_ack)  state_d = ST_RESP;
        else if (q_rty)      state_d = retry_hit ? ST_RESP : ST_BACKOFF;
        else if (tmo_hit)    state_d = ST_RESP;
      end
      ST_BACKOFF: state_d = ST_REQ;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Request latch, inline retry/timeout counters and response registers.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      lock_q       <= 1'b0;
      retry_q      <= '0;
      tmo_q        <= '0;
      rsp_dat_q    <= '0;
      rsp_status_q <= WB_OK;
    end else begin
      if (accept) begin
        adr_q   <= req_adr_i;
        dat_q   <= req_dat_i;
        sel_q   <= req_sel_i;
        we_q    <= req_we_i;
        lock_q  <= req_lock_i;
        retry_q <= '0;
        tmo_q   <= '0;
      end
      if (state_q == ST_BACKOFF) tmo_q <= '0;
      if (state_q == ST_REQ) begin
        // Counters stop at their limit because the FSM leaves REQ there.
        if (!q_term) tmo_q <= tmo_next;
        if (q_rty) retry_q <= retry_next;
        if (q_err) begin
          rsp_status_q <= WB_ERR;
        end else if (q_ack) begin
          rsp_status_q <= WB_OK;
          if (!we_q) rsp_dat_q <= bus_in.dat;
        end else if (q_rty && retry_hit) begin
          rsp_status_q <= WB_RTY_EXH;
        end else if (tmo_hit) begin
          rsp_status_q <= WB_TIMEOUT;
        end
      end
    end
  end

  // Outputs decoded from state: the bus is driven only while in REQ.
  always_comb begin
    bus_out      = '0;
    bus_out.adr  = adr_q;
    bus_out.dat  = dat_q;
    bus_out.sel  = sel_q;
    bus_out.we   = we_q;
    bus_out.cyc  = (state_q == ST_REQ);
    bus_out.stb  = (state_q == ST_REQ);
    bus_out.lock = (state_q == ST_REQ) && lock_q;
    req_ready_o  = (state_q == ST_IDLE);
    rsp_valid_o  = (state_q == ST_RESP);
  end

  assign wb_bus.wb_adr_o  = bus_out.adr;
  assign wb_bus.wb_dat_o  = bus_out.dat;
  assign wb_bus.wb_sel_o  = bus_out.sel;
  assign wb_bus.wb_we_o   = bus_out.we;
  assign wb_bus.wb_cyc_o  = bus_out.cyc;
  assign wb_bus.wb_stb_o  = bus_out.stb;
  assign wb_bus.wb_lock_o = bus_out.lock;
  assign wb_bus.wb_tga_o  = {TAGSIZE{1'b0}};
  assign wb_bus.wb_tgd_o  = {TAGSIZE{1'b0}};
  assign wb_bus.wb_tgc_o  = {TAGSIZE{1'b0}};

  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_wishbone_master.sv
// Directed bench for wishbone_master: reset, read/write, grant gating,
// retry exhaustion, timeout, termination priority, throughput, mid-cycle reset.
module tb_wishbone_master;
  import wishbone_pkg::*;

  localparam int TAGSIZE   = 2;
  localparam int MAX_RETRY = 4;
  localparam int TIMEOUT   = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, req_lock;
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  wb_state_e   state;

  wishbone_master_if #(.TAGSIZE(TAGSIZE)) bus ();

  wishbone_master #(
    .TAGSIZE(TAGSIZE), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_adr_i(req_adr), .req_dat_i(req_dat), .req_sel_i(req_sel),
    .req_lock_i(req_lock),
    .rsp_valid_o(rsp_valid), .rsp_dat_o(rsp_dat), .rsp_status_o(rsp_status),
    .wb_bus(bus), .state_o(state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_rsp    = 0;
  int          n_push   = 0;
  logic [33:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_rsp(input logic [1:0] st, input logic [31:0] d);
    exp_q.push_back({st, d});
    n_push++;
  endtask

  // Every response pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (rstn && rsp_valid) begin
      logic [33:0] e;
      n_rsp++;
      check("rsp_expected", 64'(exp_q.size() > 0), 64'(1'b1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rsp_status", 64'(rsp_status), 64'(e[33:32]));
        check("rsp_dat", 64'(rsp_dat), 64'(e[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_quiet;
    bus.wb_gnt_i = 1'b0;
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_rty_i = 1'b0;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic lock);
    req_valid = 1'b1;
    req_we    = we;
    req_adr   = adr;
    req_dat   = dat;
    req_sel   = sel;
    req_lock  = lock;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] cyc_pat;
    logic [5:0] rdy_pat;
    int drops;

    rstn = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_lock = 1'b0;
    req_adr = '0; req_dat = '0; req_sel = '0;
    bus_quiet();
    bus.wb_dat_i = '0;
    bus.wb_tgd_i = '1;
    tick(); tick();

    // Reset state
    check("rst_state", 64'(state), 64'(ST_IDLE));
    check("rst_cyc", 64'(bus.wb_cyc_o), 64'(1'b0));
    check("rst_stb", 64'(bus.wb_stb_o), 64'(1'b0));
    check("rst_lock", 64'(bus.wb_lock_o), 64'(1'b0));
    check("rst_adr", 64'(bus.wb_adr_o), 64'(32'h0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(1'b0));
    check("rst_rsp_dat", 64'(rsp_dat), 64'(32'h0));
    check("rst_rsp_status", 64'(rsp_status), 64'(2'b00));
    check("rst_tags", 64'({bus.wb_tga_o, bus.wb_tgd_o, bus.wb_tgc_o}), 64'(6'h0));
    rstn = 1'b1;
    tick();

    // Read: accept N, gnt from N+1, ack at N+2, response at N+3
    drive_req(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0);
    check("rd_ready", 64'(req_ready), 64'(1'b1));
    tick();
    req_valid = 1'b0; bus.wb_gnt_i = 1'b1;
    check("rd_cyc", 64'(bus.wb_cyc_o), 64'(1'b1));
    check("rd_stb", 64'(bus.wb_stb_o), 64'(1'b1));
    check("rd_adr", 64'(bus.wb_adr_o), 64'(32'h10));
    check("rd_we", 64'(bus.wb_we_o), 64'(1'b0));
    check("rd_ready_busy", 64'(req_ready), 64'(1'b0));
    tick();
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hDEAD_BEEF;
    expect_rsp(2'b00, 32'hDEAD_BEEF);
    check("rd_cyc2", 64'(bus.wb_cyc_o), 64'(1'b1));
    tick();
    bus_quiet();
    check("rd_rsp_valid", 64'(rsp_valid), 64'(1'b1));
    check("rd_cyc_after", 64'(bus.wb_cyc_o), 64'(1'b0));
    tick();
    check("rd_rsp_pulse", 64'(rsp_valid), 64'(1'b0));
    check("rd_ready_again", 64'(req_ready), 64'(1'b1));

    // Locked write; gnt low 3 cycles, ungranted ack in the middle is ignored
    drive_req(1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 4'b0011, 1'b1);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.wb_gnt_i = 1'b0;
      bus.wb_ack_i = (i == 1);
      check("wr_cyc_hold", 64'(bus.wb_cyc_o), 64'(1'b1));
      check("wr_sel", 64'(bus.wb_sel_o), 64'(4'b0011));
      check("wr_dat", 64'(bus.wb_dat_o), 64'(32'hA5A5_A5A5));
      check("wr_lock", 64'(bus.wb_lock_o), 64'(1'b1));
      tick();
    end
    bus.wb_gnt_i = 1'b1; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h5555_0000;
    expect_rsp(2'b00, 32'hDEAD_BEEF);
    check("wr_we", 64'(bus.wb_we_o), 64'(1'b1));
    tick();
    bus_quiet();
    check("wr_rsp_valid", 64'(rsp_valid), 64'(1'b1));
    check("wr_lock_off", 64'(bus.wb_lock_o), 64'(1'b0));
    tick();

    // Retry on every granted cycle: three one-cycle drops then exhaustion
    drive_req(1'b0, 32'h0000_0030, 32'h0, 4'hF, 1'b0);
    tick();
    req_valid = 1'b0; bus.wb_gnt_i = 1'b1; bus.wb_rty_i = 1'b1;
    expect_rsp(2'b10, 32'hDEAD_BEEF);
    cyc_pat = 7'b1010101;
    drops = 0;
    for (int i = 0; i < 7; i++) begin
      check("rty_cyc", 64'(bus.wb_cyc_o), 64'(cyc_pat[i]));
      check("rty_state", 64'(state), 64'(cyc_pat[i] ? ST_REQ : ST_BACKOFF));
      if (!bus.wb_cyc_o) drops++;
      tick();
    end
    bus_quiet();
    check("rty_drops", 64'(drops), 64'(3));
    check("rty_rsp_valid", 64'(rsp_valid), 64'(1'b1));
    tick();

    // Timeout: granted, never terminated, response 9 cycles after accept
    drive_req(1'b0, 32'h0000_0040, 32'h0, 4'hF, 1'b0);
    tick();
    req_valid = 1'b0; bus.wb_gnt_i = 1'b1;
    expect_rsp(2'b11, 32'hDEAD_BEEF);
    for (int i = 0; i < 8; i++) begin
      check("tmo_cyc", 64'(bus.wb_cyc_o), 64'(1'b1));
      check("tmo_no_rsp", 64'(rsp_valid), 64'(1'b0));
      tick();
    end
    check("tmo_rsp_valid", 64'(rsp_valid), 64'(1'b1));
    check("tmo_cyc_low", 64'(bus.wb_cyc_o), 64'(1'b0));
    tick();
    check("tmo_cyc_after", 64'(bus.wb_cyc_o), 64'(1'b0));
    bus_quiet();

    // Ack in the very cycle the timeout count is reached wins
    drive_req(1'b0, 32'h0000_0044, 32'h0, 4'hF, 1'b0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    bus.wb_gnt_i = 1'b1; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h1234_5678;
    expect_rsp(2'b00, 32'h1234_5678);
    tick();
    bus_quiet();
    check("race_rsp_valid", 64'(rsp_valid), 64'(1'b1));
    tick();

    // err + ack + rty together: err wins, read data not captured
    drive_req(1'b0, 32'h0000_0050, 32'h0, 4'hF, 1'b0);
    tick();
    req_valid = 1'b0;
    bus.wb_gnt_i = 1'b1; bus.wb_err_i = 1'b1; bus.wb_ack_i = 1'b1; bus.wb_rty_i = 1'b1;
    bus.wb_dat_i = 32'h0BAD_F00D;
    expect_rsp(2'b01, 32'h1234_5678);
    tick();
    bus_quiet();
    check("err_rsp_valid", 64'(rsp_valid), 64'(1'b1));
    tick();

    // ack + rty together: ack wins
    drive_req(1'b0, 32'h0000_0054, 32'h0, 4'hF, 1'b0);
    tick();
    req_valid = 1'b0;
    bus.wb_gnt_i = 1'b1; bus.wb_ack_i = 1'b1; bus.wb_rty_i = 1'b1;
    expect_rsp(2'b00, 32'h0BAD_F00D);
    tick();
    bus_quiet();
    check("ackrty_rsp_valid", 64'(rsp_valid), 64'(1'b1));
    tick();

    // Back-to-back: one request per 3 cycles
    drive_req(1'b0, 32'h0000_0060, 32'h0, 4'hF, 1'b0);
    bus.wb_gnt_i = 1'b1; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hCAFE_F00D;
    expect_rsp(2'b00, 32'hCAFE_F00D);
    expect_rsp(2'b00, 32'hCAFE_F00D);
    rdy_pat = 6'b001001;
    for (int i = 0; i < 6; i++) begin
      check("b2b_ready", 64'(req_ready), 64'(rdy_pat[i]));
      tick();
    end
    req_valid = 1'b0;
    bus_quiet();
    tick();

    // Reset in the middle of REQ: cyc drops, no response, ready afterwards
    drive_req(1'b0, 32'h0000_0070, 32'h0, 4'hF, 1'b1);
    tick();
    req_valid = 1'b0;
    check("mid_cyc", 64'(bus.wb_cyc_o), 64'(1'b1));
    rstn = 1'b0;
    tick();
    bus.wb_gnt_i = 1'b1; bus.wb_ack_i = 1'b1;
    check("mid_rst_cyc", 64'(bus.wb_cyc_o), 64'(1'b0));
    check("mid_rst_lock", 64'(bus.wb_lock_o), 64'(1'b0));
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(1'b0));
    check("mid_rst_status", 64'(rsp_status), 64'(2'b00));
    check("mid_rst_dat", 64'(rsp_dat), 64'(32'h0));
    rstn = 1'b1;
    tick();
    bus_quiet();
    check("mid_ready", 64'(req_ready), 64'(1'b1));
    check("mid_no_rsp", 64'(rsp_valid), 64'(1'b0));
    check("mid_cyc_idle", 64'(bus.wb_cyc_o), 64'(1'b0));
    tick(); tick();

    // ---------------- final report ----------------
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    check("rsp_count", 64'(n_rsp), 64'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
